// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory access sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mem_pkg;

    localparam int WORD_W        = 16;
    localparam int MEM_WORDS_DEF = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2,
        FAULT  = 2'd3
    } state_t;

    localparam logic OP_LOAD  = 1'b0;
    localparam logic OP_STORE = 1'b1;

endpackage

// File: rtl/mem_access_unit.sv
// Sequences one load/store at a time onto the data Memory port and range-checks the address.
// Latency: load READ_LATENCY+1 cycles, store 2 cycles, fault 1 cycle (req edge to done-high cycle).
// Backpressure: busy is high outside IDLE; req while busy is dropped, requester re-asserts after done.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int MEM_WORDS    = MEM_WORDS_DEF,
    parameter int READ_LATENCY = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req,
    input  logic                     we,
    input  logic        [WORD_W-1:0] addr,
    input  logic signed [WORD_W-1:0] wdata,
    output logic                     busy,
    output logic                     done,
    output logic                     fault,
    output logic signed [WORD_W-1:0] rdata,
    output logic        [WORD_W-1:0] mem_address,
    output logic signed [WORD_W-1:0] mem_write_data,
    output logic                     mem_r_flag,
    output logic                     mem_w_flag,
    input  logic signed [WORD_W-1:0] mem_read_data
);

    localparam int CNT_W = $clog2(READ_LATENCY + 1);
    // One extra bit so a MEM_WORDS of 2**WORD_W still compares correctly.
    localparam logic [WORD_W:0] ADDR_LIMIT = (WORD_W + 1)'(MEM_WORDS);

    state_t             state;
    logic               op;
    logic [CNT_W-1:0]   lat_cnt;

    // Busy is a pure decode of the registered state.
    assign busy = (state != IDLE);

    // Request capture, memory strobe sequencing and completion handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            op             <= OP_LOAD;
            lat_cnt        <= '0;
            done           <= 1'b0;
            fault          <= 1'b0;
            rdata          <= '0;
            mem_address    <= '0;
            mem_write_data <= '0;
            mem_r_flag     <= 1'b0;
            mem_w_flag     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done  <= 1'b0;
                    fault <= 1'b0;
                    if (req) begin
                        op             <= we;
                        mem_address    <= addr;
                        mem_write_data <= wdata;
                        if ({1'b0, addr} >= ADDR_LIMIT) begin
                            // Out of range: report immediately, never touch the memory.
                            state <= FAULT;
                            done  <= 1'b1;
                            fault <= 1'b1;
                        end else begin
                            state   <= ACCESS;
                            lat_cnt <= CNT_W'(READ_LATENCY);
                            if (we == OP_STORE) begin
                                mem_w_flag <= 1'b1;
                            end else begin
                                mem_r_flag <= 1'b1;
                            end
                        end
                    end
                end
                ACCESS: begin
                    if (op == OP_STORE) begin
                        // Single write cycle regardless of read latency.
                        mem_w_flag <= 1'b0;
                        done       <= 1'b1;
                        state      <= DONE;
                    end else if (lat_cnt <= CNT_W'(1)) begin
                        // Last read cycle: memory data is valid at this edge.
                        mem_r_flag <= 1'b0;
                        rdata      <= mem_read_data;
                        lat_cnt    <= '0;
                        done       <= 1'b1;
                        state      <= DONE;
                    end else begin
                        lat_cnt <= lat_cnt - CNT_W'(1);
                    end
                end
                DONE, FAULT: begin
                    done  <= 1'b0;
                    fault <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: transaction-timeline reference model plus directed and random stimulus.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_access_unit;

    localparam int RL = 3;
    localparam int MW = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        busy, done, fault;
    logic [15:0] rdata, mem_address, mem_write_data, mem_read_data;
    logic        mem_r_flag, mem_w_flag;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.MEM_WORDS(MW), .READ_LATENCY(RL)) dut (
        .clk            (clk),
        .reset          (reset),
        .req            (req),
        .we             (we),
        .addr           (addr),
        .wdata          (wdata),
        .busy           (busy),
        .done           (done),
        .fault          (fault),
        .rdata          (rdata),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_r_flag     (mem_r_flag),
        .mem_w_flag     (mem_w_flag),
        .mem_read_data  (mem_read_data)
    );

    // Memory environment: data only valid in the last of RL consecutive read cycles.
    logic [15:0] mem [16];
    int          rcnt = 0;
    assign mem_read_data = (mem_r_flag && rcnt == RL - 1) ? mem[mem_address[3:0]] : 16'hDEAD;
    always @(posedge clk) begin
        if (mem_w_flag) mem[mem_address[3:0]] <= mem_write_data;
        rcnt <= (mem_r_flag && !reset) ? rcnt + 1 : 0;
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each accepted request expands into a timeline of per-cycle outputs.
    typedef struct packed {
        logic busy;
        logic r;
        logic w;
        logic done;
        logic fault;
        logic ld;
    } ph_t;

    ph_t         cur = '0;
    ph_t         plan[$];
    logic [15:0] ref_mem [16];
    logic [15:0] e_rdata = '0, e_addr = '0, e_wdata = '0;
    logic        model_on = 1'b0;

    function automatic ph_t mk(input logic b, input logic r, input logic w,
                               input logic d, input logic f, input logic l);
        ph_t p;
        p.busy = b; p.r = r; p.w = w; p.done = d; p.fault = f; p.ld = l;
        return p;
    endfunction

    always @(posedge clk) begin
        if (cur.w) ref_mem[e_addr[3:0]] = e_wdata;
        if (reset) begin
            plan.delete();
            cur      = '0;
            e_rdata  = '0;
            e_addr   = '0;
            e_wdata  = '0;
            model_on = 1'b1;
        end else begin
            if (!cur.busy && req) begin
                e_addr  = addr;
                e_wdata = wdata;
                if (int'(addr) >= MW) begin
                    plan.push_back(mk(1, 0, 0, 1, 1, 0));
                end else if (we) begin
                    plan.push_back(mk(1, 0, 1, 0, 0, 0));
                    plan.push_back(mk(1, 0, 0, 1, 0, 0));
                end else begin
                    for (int i = 0; i < RL; i++) plan.push_back(mk(1, 1, 0, 0, 0, 0));
                    plan.push_back(mk(1, 0, 0, 1, 0, 1));
                end
            end
            if (plan.size() > 0) cur = plan.pop_front();
            else                 cur = '0;
            if (cur.ld) e_rdata = ref_mem[e_addr[3:0]];
        end
    end

    // Cycle-by-cycle compare of every DUT output against the model.
    always @(negedge clk) begin
        if (model_on) begin
            chk("busy",  {15'd0, busy},       {15'd0, cur.busy});
            chk("done",  {15'd0, done},       {15'd0, cur.done});
            chk("fault", {15'd0, fault},      {15'd0, cur.fault});
            chk("rflag", {15'd0, mem_r_flag}, {15'd0, cur.r});
            chk("wflag", {15'd0, mem_w_flag}, {15'd0, cur.w});
            chk("rdata", rdata, e_rdata);
            chk("maddr", mem_address, e_addr);
            chk("mwdat", mem_write_data, e_wdata);
            chk("flags_exclusive", {15'd0, mem_r_flag & mem_w_flag}, 16'd0);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
        req = r; we = w; addr = a; wdata = d;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i]     = 16'($urandom);
            ref_mem[i] = mem[i];
        end
        reset = 1'b1;
        drive(0, 0, 16'd0, 16'd0);

        // 1. reset held two cycles, then first post-reset cycle is all zero
        step(); step();
        reset = 1'b0;
        step();
        chk("rst_busy",  {15'd0, busy}, 16'd0);
        chk("rst_done",  {15'd0, done}, 16'd0);
        chk("rst_fault", {15'd0, fault}, 16'd0);
        chk("rst_rdata", rdata, 16'd0);
        chk("rst_maddr", mem_address, 16'd0);
        chk("rst_flags", {14'd0, mem_r_flag, mem_w_flag}, 16'd0);

        // 2. store -5 to address 3
        drive(1, 1, 16'd3, 16'hFFFB);
        step();
        drive(0, 0, 16'd0, 16'd0);
        chk("st_wflag", {15'd0, mem_w_flag}, 16'd1);
        chk("st_addr",  mem_address, 16'd3);
        chk("st_wdata", mem_write_data, 16'hFFFB);
        step();
        chk("st_done",  {15'd0, done}, 16'd1);
        chk("st_wflag_off", {15'd0, mem_w_flag}, 16'd0);
        step();

        // 3. load from address 3, then a store must leave rdata alone
        drive(1, 0, 16'd3, 16'd0);
        step();
        drive(0, 0, 16'd0, 16'd0);
        chk("ld_r1", {15'd0, mem_r_flag}, 16'd1);
        step();
        step();
        chk("ld_r3", {15'd0, mem_r_flag}, 16'd1);
        step();
        chk("ld_done",  {15'd0, done}, 16'd1);
        chk("ld_rdata", rdata, 16'hFFFB);
        step();
        drive(1, 1, 16'd5, 16'h1234);
        step();
        drive(0, 0, 16'd0, 16'd0);
        step();
        chk("st2_done",  {15'd0, done}, 16'd1);
        chk("rdata_hold", rdata, 16'hFFFB);
        step();

        // 4. out-of-range addresses
        drive(1, 0, 16'd16, 16'd0);
        step();
        drive(0, 0, 16'd0, 16'd0);
        chk("flt16_done",  {15'd0, done}, 16'd1);
        chk("flt16_fault", {15'd0, fault}, 16'd1);
        chk("flt16_rdata", rdata, 16'hFFFB);
        step();
        drive(1, 1, 16'hFFFF, 16'h5555);
        step();
        drive(0, 0, 16'd0, 16'd0);
        chk("fltFFFF_fault", {15'd0, fault}, 16'd1);
        chk("fltFFFF_flags", {14'd0, mem_r_flag, mem_w_flag}, 16'd0);
        step();

        // 6. reset during second read cycle, then a clean load
        drive(1, 0, 16'd3, 16'd0);
        step();
        drive(0, 0, 16'd0, 16'd0);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rstmid_busy",  {15'd0, busy}, 16'd0);
        chk("rstmid_done",  {15'd0, done}, 16'd0);
        chk("rstmid_rflag", {15'd0, mem_r_flag}, 16'd0);
        chk("rstmid_rdata", rdata, 16'd0);
        drive(1, 0, 16'd5, 16'd0);
        step();
        drive(0, 0, 16'd0, 16'd0);
        step(); step(); step();
        chk("reload_done",  {15'd0, done}, 16'd1);
        chk("reload_rdata", rdata, 16'h1234);
        step();

        // 5. req held high, alternating load/store on each completion
        we = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (done) we = ~we;
            req   = 1'b1;
            addr  = 16'($urandom_range(0, 15));
            wdata = 16'($urandom);
            step();
        end
        drive(0, 0, 16'd0, 16'd0);
        repeat (6) step();

        // Random traffic with occasional resets and bad addresses
        for (int i = 0; i < 1500; i++) begin
            int sel;
            reset = ($urandom_range(0, 99) == 0);
            req   = ($urandom_range(0, 2) != 0);
            we    = 1'($urandom_range(0, 1));
            sel   = $urandom_range(0, 9);
            if (sel == 0)      addr = 16'hFFFF;
            else if (sel == 1) addr = 16'($urandom_range(16, 65535));
            else               addr = 16'($urandom_range(0, 15));
            wdata = 16'($urandom);
            step();
        end
        reset = 1'b0;
        drive(0, 0, 16'd0, 16'd0);
        repeat (8) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
